// File: rtl/deadlock_idx0_monitor_if.sv
// ---------------------------------------------------------------------------
// deadlock_idx0_monitor_if
//
// Groups the flags that a dataflow region exposes to its deadlock monitor,
// together with the monitor's verdict.
//
// Signals:
//   axis_block_sigs [N_AXIS-1:0] : 1 = top-level AXIS port stalled on the environment
//   inst_idle_sigs  [N_IDLE-1:0] : 1 = process / auxiliary instance idle
//                                  ([N_INST-1:0] per process, rest auxiliary)
//   inst_block_sigs [N_INST-1:0] : 1 = process stalled on an internal FIFO/handshake
//   block                        : sticky deadlock verdict from the monitor
//
// Modports:
//   master : the region side (drives the flags, observes the verdict)
//   slave  : the monitor side (samples the flags, drives the verdict)
// ---------------------------------------------------------------------------
interface deadlock_idx0_monitor_if #(
    parameter int N_AXIS = 2,
    parameter int N_INST = 14,
    parameter int N_IDLE = 18
);

    logic [N_AXIS-1:0] axis_block_sigs;
    logic [N_IDLE-1:0] inst_idle_sigs;
    logic [N_INST-1:0] inst_block_sigs;
    logic              block;

    modport master (
        output axis_block_sigs,
        output inst_idle_sigs,
        output inst_block_sigs,
        input  block
    );

    modport slave (
        input  axis_block_sigs,
        input  inst_idle_sigs,
        input  inst_block_sigs,
        output block
    );

endinterface

// File: rtl/deadlock_idx0_monitor.sv
// ---------------------------------------------------------------------------
// deadlock_idx0_monitor
//
// Deadlock detector for dataflow region 0 of the myproject kernel. A cycle is
// a deadlock candidate when the region is not fully idle, every process is
// either idle or stalled, at least one process is stalled, and no external
// AXIS port is stalled. THRESHOLD consecutive candidate cycles latch a sticky
// block flag that only reset clears.
//
// Ports:
//   clock : rising-edge clock
//   reset : asynchronous, active-high reset
//   mon   : slave modport of deadlock_idx0_monitor_if
//             axis_block_sigs, inst_idle_sigs, inst_block_sigs in, block out
//
// State table:
//   state     | meaning
//   ST_WATCH  | counting consecutive candidate cycles in cnt, block = 0
//   ST_LOCKED | deadlock seen, block = 1, cnt frozen until reset
// ---------------------------------------------------------------------------
module deadlock_idx0_monitor #(
    parameter int N_AXIS    = 2,
    parameter int N_INST    = 14,
    parameter int N_IDLE    = 18,
    parameter int THRESHOLD = 16
) (
    input  logic                    clock,
    input  logic                    reset,
    deadlock_idx0_monitor_if.slave  mon
);

    localparam int CNT_W = (THRESHOLD < 1) ? 1 : $clog2(THRESHOLD + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(THRESHOLD - 1);

    typedef enum logic [0:0] {
        ST_WATCH  = 1'b0,
        ST_LOCKED = 1'b1
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic             block_q;

    logic all_idle;
    logic all_stuck;
    logic any_blk;
    logic ext_blk;
    logic cand;

    // A fully idle region (including auxiliary instances) is simply finished,
    // and an external stall means the environment is slow; neither counts.
    assign all_idle  = &mon.inst_idle_sigs;
    assign all_stuck = &(mon.inst_idle_sigs[N_INST-1:0] | mon.inst_block_sigs);
    assign any_blk   = |mon.inst_block_sigs;
    assign ext_blk   = |mon.axis_block_sigs;
    assign cand      = ~all_idle & all_stuck & any_blk & ~ext_blk;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state   <= ST_WATCH;
            cnt     <= '0;
            block_q <= 1'b0;
        end else begin
            case (state)
                ST_WATCH: begin
                    if (cand) begin
                        // cnt holds the number of candidate edges already seen,
                        // so the THRESHOLD-th one locks instead of counting.
                        if (cnt == CNT_LAST) begin
                            state   <= ST_LOCKED;
                            block_q <= 1'b1;
                        end else begin
                            cnt <= cnt + CNT_W'(1);
                        end
                    end else begin
                        cnt <= '0;
                    end
                end
                ST_LOCKED: begin
                    block_q <= 1'b1;
                end
                default: begin
                    state   <= ST_WATCH;
                    cnt     <= '0;
                    block_q <= 1'b0;
                end
            endcase
        end
    end

    assign mon.block = block_q;

endmodule

// File: tb/tb_deadlock_idx0_monitor.sv
module tb_deadlock_idx0_monitor;

    localparam int N_AXIS    = 2;
    localparam int N_INST    = 14;
    localparam int N_IDLE    = 18;
    localparam int THRESHOLD = 16;

    localparam logic [N_IDLE-1:0] DL_IDLE = 18'h03FF7;
    localparam logic [N_INST-1:0] DL_BLK  = 14'h0008;

    logic clock = 1'b0;
    logic reset;

    deadlock_idx0_monitor_if #(.N_AXIS(N_AXIS), .N_INST(N_INST), .N_IDLE(N_IDLE)) mon_if ();

    deadlock_idx0_monitor #(
        .N_AXIS   (N_AXIS),
        .N_INST   (N_INST),
        .N_IDLE   (N_IDLE),
        .THRESHOLD(THRESHOLD)
    ) dut (
        .clock(clock),
        .reset(reset),
        .mon  (mon_if)
    );

    always #5 clock = ~clock;

    int n_checks = 0;
    int n_errors = 0;

    // Reference: how many consecutive candidate edges have been seen, and
    // whether the deadlock verdict has been reached.
    int ref_run   = 0;
    bit ref_block = 1'b0;

    task automatic chk(input string tag, input logic obs, input logic exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: block=%b expected %b at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic bit ref_cand();
        int n_idle_all = 0;
        int n_stuck    = 0;
        int n_blk      = 0;
        int n_ext      = 0;
        for (int i = 0; i < N_IDLE; i++)
            if (mon_if.inst_idle_sigs[i]) n_idle_all++;
        for (int i = 0; i < N_INST; i++) begin
            if (mon_if.inst_idle_sigs[i] || mon_if.inst_block_sigs[i]) n_stuck++;
            if (mon_if.inst_block_sigs[i]) n_blk++;
        end
        for (int i = 0; i < N_AXIS; i++)
            if (mon_if.axis_block_sigs[i]) n_ext++;
        return (n_idle_all != N_IDLE) && (n_stuck == N_INST) && (n_blk > 0) && (n_ext == 0);
    endfunction

    task automatic drive(input logic [N_IDLE-1:0] idle, input logic [N_INST-1:0] blk,
                         input logic [N_AXIS-1:0] axis);
        mon_if.inst_idle_sigs  = idle;
        mon_if.inst_block_sigs = blk;
        mon_if.axis_block_sigs = axis;
    endtask

    task automatic step(input string tag);
        @(posedge clock);
        if (!ref_block) begin
            if (ref_cand()) begin
                ref_run++;
                if (ref_run >= THRESHOLD) ref_block = 1'b1;
            end else begin
                ref_run = 0;
            end
        end
        @(negedge clock);
        chk(tag, mon_if.block, ref_block);
    endtask

    task automatic steps(input string tag, input int n);
        for (int k = 0; k < n; k++) step(tag);
    endtask

    // Called just after a falling edge: the pulse lies entirely between edges.
    task automatic pulse_reset();
        #1 reset = 1'b1;
        #1 chk("rst_async", mon_if.block, 1'b0);
        ref_run   = 0;
        ref_block = 1'b0;
        #1 reset = 1'b0;
    endtask

    initial begin
        logic [N_IDLE-1:0] r_idle;
        logic [N_INST-1:0] r_blk;
        logic [N_AXIS-1:0] r_axis;
        int                mode;
        int                pick;

        reset = 1'b1;
        drive('0, '0, '0);
        repeat (3) @(negedge clock);
        chk("rst_hold", mon_if.block, 1'b0);
        reset = 1'b0;

        steps("busy", 50);
        chk("busy_end", mon_if.block, 1'b0);

        drive('1, '0, '0);
        steps("all_idle", 40);
        chk("all_idle_end", mon_if.block, 1'b0);

        drive(DL_IDLE, DL_BLK, '0);
        steps("dl_pre", THRESHOLD - 1);
        chk("dl_15", mon_if.block, 1'b0);
        step("dl_16");
        chk("dl_rise", mon_if.block, 1'b1);
        drive('0, '0, '0);
        steps("sticky", 20);
        chk("sticky_end", mon_if.block, 1'b1);
        pulse_reset();

        drive(DL_IDLE, DL_BLK, '0);
        steps("brk_pre", THRESHOLD - 1);
        drive(DL_IDLE, '0, '0);
        step("brk_gap");
        chk("brk_gap_c", mon_if.block, 1'b0);
        drive(DL_IDLE, DL_BLK, '0);
        steps("brk_restart", THRESHOLD - 1);
        chk("brk_15", mon_if.block, 1'b0);
        step("brk_16");
        chk("brk_rise", mon_if.block, 1'b1);
        pulse_reset();

        drive(DL_IDLE, DL_BLK, 2'b01);
        steps("ext", 100);
        chk("ext_end", mon_if.block, 1'b0);
        drive(DL_IDLE, DL_BLK, '0);
        steps("ext_clr", THRESHOLD - 1);
        chk("ext_clr_15", mon_if.block, 1'b0);
        step("ext_clr_16");
        chk("ext_clr_rise", mon_if.block, 1'b1);

        pulse_reset();
        steps("rearm", THRESHOLD - 1);
        chk("rearm_15", mon_if.block, 1'b0);
        step("rearm_16");
        chk("rearm_rise", mon_if.block, 1'b1);
        pulse_reset();

        for (int seg = 0; seg < 150; seg++) begin
            mode = $urandom_range(0, 5);
            if (mode == 0) begin
                r_idle = N_IDLE'($urandom);
                r_blk  = N_INST'($urandom);
                r_axis = N_AXIS'($urandom);
            end else if (mode == 5) begin
                r_idle = '1;
                r_blk  = N_INST'($urandom) & N_INST'($urandom);
                r_axis = '0;
            end else begin
                r_blk = N_INST'($urandom) & N_INST'($urandom) & N_INST'($urandom);
                if (r_blk == '0) r_blk[$urandom_range(0, N_INST - 1)] = 1'b1;
                r_idle = N_IDLE'($urandom);
                r_idle[N_INST-1:0] = r_idle[N_INST-1:0] | ~r_blk;
                r_axis = ($urandom_range(0, 5) == 0) ? N_AXIS'($urandom) : '0;
                if (mode == 4) begin
                    pick = $urandom_range(0, N_INST - 1);
                    r_idle[pick] = 1'b0;
                    r_blk[pick]  = 1'b0;
                end
            end
            drive(r_idle, r_blk, r_axis);
            steps("rand", $urandom_range(1, 24));
            if (ref_block && $urandom_range(0, 2) == 0) pulse_reset();
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
